ibex_irq_arbiter: RTL and testbench
===================================

IBEX_IRQ_ARBITER -- requirements
Module: ibex_irq_arbiter

Interface
REQ-001 Parameter: NUM_SRC, default 32, number of interrupt sources; legal range 1..32.
REQ-002 Parameter: EDGE_MASK, default '0 (NUM_SRC bits), per-source trigger type; bit k=1 means edge-triggered, 0 means level-triggered.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: irq_src_i  input  NUM_SRC  raw interrupt source lines.
REQ-006 Port: irq_en_i  input  NUM_SRC  per-source enable mask from CSR.
REQ-007 Port: irq_ack_i  input  1  interrupt controller has accepted the presented interrupt.
REQ-008 Port: irq_o  output  1  interrupt request to the interrupt controller (its irq_i).
REQ-009 Port: irq_id_o  output  5  id of the presented interrupt (to its irq_id_i).
REQ-010 Port: irq_pending_o  output  NUM_SRC  effective pending vector, unmasked, for CSR read-back.

Function
REQ-011 src_q SHALL register irq_src_i every cycle.
REQ-012 For edge sources, pend_q[k] SHALL be set when irq_src_i[k]=1 and src_q[k]=0.
REQ-013 Effective pending SHALL be: edge source pend_q[k]; level source src_q[k]; irq_pending_o equals this vector combinationally.
REQ-014 active[k] SHALL be effective pending[k] AND irq_en_i[k].
REQ-015 Winner SHALL be the lowest-index active source (fixed priority, index 0 highest).
REQ-016 FSM states SHALL be IDLE, PRESENT, WAIT_CLR; irq_o and irq_id_o SHALL be registered.
REQ-017 IDLE: if any active bit is set, next cycle irq_o=1, irq_id_o=winner, go PRESENT; otherwise stay, irq_o=0.
REQ-018 PRESENT: irq_id_o SHALL hold stable while irq_o=1; a higher-priority arrival SHALL NOT replace it.
REQ-019 PRESENT with irq_ack_i=1: clear pend_q[irq_id_o] if that source is edge-type, irq_o=0 next cycle, go WAIT_CLR.
REQ-020 PRESENT with irq_ack_i=0 and active[irq_id_o]=0 (level dropped or enable cleared): irq_o=0 next cycle, go IDLE (withdraw); pend_q unchanged.
REQ-021 Ack and withdraw in the same cycle: ack SHALL take precedence.
REQ-022 WAIT_CLR: irq_o=0 for exactly one cycle, then go IDLE; it prevents re-presenting before the controller returns to idle.
REQ-023 Set and ack-clear of the same edge bit in the same cycle: set SHALL win (pend_q stays 1).
REQ-024 irq_ack_i in IDLE or WAIT_CLR SHALL be ignored.
REQ-025 Latency: a source sampled high (enabled, FSM IDLE) at edge E0 SHALL give irq_o=1 after edge E1.
REQ-026 irq_id_o SHALL always be < NUM_SRC; upper bits zero-extended.
REQ-027 Level sources SHALL NOT be cleared by ack; they re-present after WAIT_CLR if still high.

Reset
REQ-028 While rst=1 at a clock edge: src_q=0, pend_q=0, state=IDLE, irq_o=0, irq_id_o=0.
REQ-029 Reset asserted mid-PRESENT SHALL drop irq_o the next edge and discard all pending edges.
REQ-030 First cycle after reset release SHALL treat sources already high as rising edges (src_q=0).

Verification
REQ-031 Level src 3 enabled, held high from E0 -> irq_o=1, irq_id_o=3 after E1; ack at E4 -> irq_o=0 for E5..E6, re-asserted id 3 after E7.
REQ-032 Edge src 5 one-cycle pulse, enable=1 -> irq_o=1, id 5; ack -> pend_q[5]=0, irq_pending_o[5]=0, no re-presentation.
REQ-033 Present id 7, then raise src 2 -> id stays 7 until ack; after WAIT_CLR, id 2 presented.
REQ-034 Edge src 4 re-pulses in the ack cycle -> pend_q[4] stays 1, id 4 presented again after WAIT_CLR.
REQ-035 Present level id 6, clear irq_en_i[6] without ack -> irq_o=0 next cycle, state IDLE, irq_pending_o[6]=1.
REQ-036 rst=1 during PRESENT with edge bits 1,9 pending -> irq_o=0, irq_id_o=0, irq_pending_o=0 after that edge.

Source files
------------

// File: rtl/ibex_irq_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ibex_irq_arbiter
// Description : Collects up to 32 raw interrupt lines (per-source edge or
//               level trigger), masks them with the CSR enable vector and
//               presents the lowest-index active source to the core's
//               interrupt controller with an irq/id/ack handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module ibex_irq_arbiter #(
    parameter int                 NUM_SRC   = 32,
    parameter logic [NUM_SRC-1:0] EDGE_MASK = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_src_i,
    input  logic [NUM_SRC-1:0] irq_en_i,
    input  logic               irq_ack_i,
    output logic               irq_o,
    output logic [4:0]         irq_id_o,
    output logic [NUM_SRC-1:0] irq_pending_o
);

    // Presentation handshake states
    localparam logic [1:0] c_state_idle     = 2'd0;
    localparam logic [1:0] c_state_present  = 2'd1;
    localparam logic [1:0] c_state_wait_clr = 2'd2;

    logic [NUM_SRC-1:0] r_src_q;
    logic [NUM_SRC-1:0] r_pend_q;
    logic [1:0]         r_state;
    logic               r_irq;
    logic [4:0]         r_irq_id;

    logic [NUM_SRC-1:0] w_rise;
    logic [NUM_SRC-1:0] w_ack_clr;
    logic [NUM_SRC-1:0] w_pend_nxt;
    logic [NUM_SRC-1:0] w_eff_pend;
    logic [NUM_SRC-1:0] w_active;
    logic [NUM_SRC-1:0] w_id_onehot;
    logic [4:0]         w_winner;
    logic               w_any_active;
    logic               w_cur_active;
    logic               w_ack_take;
    logic [1:0]         w_state_nxt;
    logic               w_irq_nxt;
    logic [4:0]         w_irq_id_nxt;

    // Edge sources latch into pend_q; level sources follow the sampled line.
    // Only the edge bits of pend_q are ever set, so the mask keeps the two
    // kinds of source cleanly separated.
    assign w_eff_pend    = (EDGE_MASK & r_pend_q) | (~EDGE_MASK & r_src_q);
    assign w_active      = w_eff_pend & irq_en_i;
    assign irq_pending_o = w_eff_pend;

    // A rising edge is judged against the previous sample; after reset the
    // previous sample is zero, so a line already high counts as an edge.
    assign w_rise = irq_src_i & ~r_src_q & EDGE_MASK;

    // Ack is only meaningful while an interrupt is being presented.
    assign w_ack_take = (r_state == c_state_present) && irq_ack_i;
    assign w_ack_clr  = w_ack_take ? (w_id_onehot & EDGE_MASK) : '0;

    // Set has priority over the ack-clear so an edge arriving in the ack
    // cycle is not lost.
    assign w_pend_nxt = (r_pend_q & ~w_ack_clr) | w_rise;

    // Decode the presented id into a source vector (avoids indexing past
    // NUM_SRC when fewer than 32 sources are configured).
    always_comb begin
        w_id_onehot = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            w_id_onehot[k] = (r_irq_id == 5'(k));
        end
    end

    assign w_cur_active = |(w_active & w_id_onehot);

    // Fixed-priority pick: scanning downwards leaves the lowest index.
    always_comb begin
        w_winner     = '0;
        w_any_active = |w_active;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (w_active[k]) begin
                w_winner = 5'(k);
            end
        end
    end

    // Next-state and next-output logic of the presentation handshake
    always_comb begin
        w_state_nxt  = r_state;
        w_irq_nxt    = r_irq;
        w_irq_id_nxt = r_irq_id;
        case (r_state)
            c_state_idle: begin
                w_irq_nxt = 1'b0;
                if (w_any_active) begin
                    w_irq_nxt    = 1'b1;
                    w_irq_id_nxt = w_winner;
                    w_state_nxt  = c_state_present;
                end
            end
            c_state_present: begin
                // The id stays frozen here; a newly arrived higher-priority
                // source waits for the next arbitration in IDLE.
                if (irq_ack_i) begin
                    w_irq_nxt   = 1'b0;
                    w_state_nxt = c_state_wait_clr;
                end else if (!w_cur_active) begin
                    w_irq_nxt   = 1'b0;
                    w_state_nxt = c_state_idle;
                end
            end
            c_state_wait_clr: begin
                // One quiet cycle lets the controller return to idle before
                // anything new is offered.
                w_irq_nxt   = 1'b0;
                w_state_nxt = c_state_idle;
            end
            default: begin
                w_irq_nxt   = 1'b0;
                w_state_nxt = c_state_idle;
            end
        endcase
    end

    // Source sampling, pending latch and handshake registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_src_q  <= '0;
            r_pend_q <= '0;
            r_state  <= c_state_idle;
            r_irq    <= 1'b0;
            r_irq_id <= '0;
        end else begin
            r_src_q  <= irq_src_i;
            r_pend_q <= w_pend_nxt;
            r_state  <= w_state_nxt;
            r_irq    <= w_irq_nxt;
            r_irq_id <= w_irq_id_nxt;
        end
    end

    assign irq_o    = r_irq;
    assign irq_id_o = r_irq_id;

endmodule
`default_nettype wire

// File: tb/tb_ibex_irq_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ibex_irq_arbiter
// Description : Directed self-checking bench for ibex_irq_arbiter. Edge
//               sources are 1, 4, 5 and 9; all others are level sources.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ibex_irq_arbiter;

    localparam int               c_num_src = 32;
    localparam logic [31:0]      c_edges   = 32'h0000_0232;

    typedef struct packed {
        logic       irq;
        logic [4:0] id;
        logic       chk_id;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [31:0] irq_src_i;
    logic [31:0] irq_en_i;
    logic        irq_ack_i;
    logic        irq_o;
    logic [4:0]  irq_id_o;
    logic [31:0] irq_pending_o;

    exp_t        sb[$];
    int          checks;
    int          failures;

    ibex_irq_arbiter #(
        .NUM_SRC   (c_num_src),
        .EDGE_MASK (c_edges)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .irq_src_i     (irq_src_i),
        .irq_en_i      (irq_en_i),
        .irq_ack_i     (irq_ack_i),
        .irq_o         (irq_o),
        .irq_id_o      (irq_id_o),
        .irq_pending_o (irq_pending_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Push the expectation for the coming edge, step one clock, then pop
    // and compare once the outputs have settled.
    task automatic cyc(input logic e_irq, input logic [4:0] e_id,
                       input logic c_id, input string tag);
        exp_t e;
        e.irq    = e_irq;
        e.id     = e_id;
        e.chk_id = c_id;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        checks++;
        assert (irq_o === e.irq) else begin
            failures++;
            $error("FAIL %s irq_o observed=%0b expected=%0b", tag, irq_o, e.irq);
        end
        if (e.chk_id) begin
            checks++;
            assert (irq_id_o === e.id) else begin
                failures++;
                $error("FAIL %s irq_id_o observed=%0d expected=%0d", tag, irq_id_o, e.id);
            end
        end
    endtask

    task automatic chk_pend(input logic [31:0] mask, input logic [31:0] exp_v,
                            input string tag);
        checks++;
        assert ((irq_pending_o & mask) === exp_v) else begin
            failures++;
            $error("FAIL %s irq_pending_o observed=%h expected=%h", tag,
                   irq_pending_o & mask, exp_v);
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        irq_src_i = '0;
        irq_en_i  = '0;
        irq_ack_i = 1'b0;

        // Reset state
        cyc(1'b0, 5'd0, 1'b1, "reset0");
        cyc(1'b0, 5'd0, 1'b1, "reset1");
        chk_pend(32'hFFFF_FFFF, 32'h0, "reset_pend");

        // Level source 3: latency, ack, WAIT_CLR, re-present, withdraw
        rst          = 1'b0;
        irq_en_i     = '1;
        irq_src_i[3] = 1'b1;
        cyc(1'b0, 5'd0, 1'b0, "lvl3_e0");
        chk_pend(32'h0000_0008, 32'h0000_0008, "lvl3_pend");
        cyc(1'b1, 5'd3, 1'b1, "lvl3_e1");
        cyc(1'b1, 5'd3, 1'b1, "lvl3_e2");
        cyc(1'b1, 5'd3, 1'b1, "lvl3_e3");
        cyc(1'b1, 5'd3, 1'b1, "lvl3_e4");
        irq_ack_i = 1'b1;
        cyc(1'b0, 5'd0, 1'b0, "lvl3_e5");
        irq_ack_i = 1'b0;
        cyc(1'b0, 5'd0, 1'b0, "lvl3_e6");
        cyc(1'b1, 5'd3, 1'b1, "lvl3_e7");
        irq_src_i[3] = 1'b0;
        cyc(1'b1, 5'd3, 1'b1, "lvl3_hold");
        cyc(1'b0, 5'd0, 1'b0, "lvl3_withdraw");
        cyc(1'b0, 5'd0, 1'b0, "lvl3_idle");

        // Edge source 5: single pulse, ack clears, no re-presentation
        irq_src_i[5] = 1'b1;
        cyc(1'b0, 5'd0, 1'b0, "edge5_e0");
        irq_src_i[5] = 1'b0;
        cyc(1'b1, 5'd5, 1'b1, "edge5_e1");
        chk_pend(32'h0000_0020, 32'h0000_0020, "edge5_pend");
        irq_ack_i = 1'b1;
        cyc(1'b0, 5'd0, 1'b0, "edge5_ack");
        irq_ack_i = 1'b0;
        chk_pend(32'h0000_0020, 32'h0, "edge5_clr");
        cyc(1'b0, 5'd0, 1'b0, "edge5_idle0");
        cyc(1'b0, 5'd0, 1'b0, "edge5_idle1");
        chk_pend(32'hFFFF_FFFF, 32'h0, "edge5_none");

        // Id 7 presented; higher-priority 2 waits until after WAIT_CLR
        irq_src_i[7] = 1'b1;
        cyc(1'b0, 5'd0, 1'b0, "pri_e0");
        cyc(1'b1, 5'd7, 1'b1, "pri_e1");
        irq_src_i[2] = 1'b1;
        cyc(1'b1, 5'd7, 1'b1, "pri_hold0");
        cyc(1'b1, 5'd7, 1'b1, "pri_hold1");
        irq_ack_i = 1'b1;
        cyc(1'b0, 5'd0, 1'b0, "pri_ack");
        irq_ack_i = 1'b0;
        cyc(1'b0, 5'd0, 1'b0, "pri_wait");
        cyc(1'b1, 5'd2, 1'b1, "pri_id2");
        irq_src_i[2] = 1'b0;
        irq_src_i[7] = 1'b0;
        cyc(1'b1, 5'd2, 1'b1, "pri_hold2");
        cyc(1'b0, 5'd0, 1'b0, "pri_withdraw");
        cyc(1'b0, 5'd0, 1'b0, "pri_idle");

        // Edge 4 re-pulses in the ack cycle: set beats the clear
        irq_src_i[4] = 1'b1;
        cyc(1'b0, 5'd0, 1'b0, "e4_e0");
        irq_src_i[4] = 1'b0;
        cyc(1'b1, 5'd4, 1'b1, "e4_e1");
        irq_ack_i    = 1'b1;
        irq_src_i[4] = 1'b1;
        cyc(1'b0, 5'd0, 1'b0, "e4_ack");
        irq_ack_i    = 1'b0;
        irq_src_i[4] = 1'b0;
        chk_pend(32'h0000_0010, 32'h0000_0010, "e4_kept");
        cyc(1'b0, 5'd0, 1'b0, "e4_wait");
        cyc(1'b1, 5'd4, 1'b1, "e4_again");
        irq_ack_i = 1'b1;
        cyc(1'b0, 5'd0, 1'b0, "e4_ack2");
        irq_ack_i = 1'b0;
        chk_pend(32'h0000_0010, 32'h0, "e4_clr");
        cyc(1'b0, 5'd0, 1'b0, "e4_idle0");
        cyc(1'b0, 5'd0, 1'b0, "e4_idle1");

        // Level 6: enable cleared without ack withdraws; ack beats withdraw
        irq_src_i[6] = 1'b1;
        cyc(1'b0, 5'd0, 1'b0, "l6_e0");
        cyc(1'b1, 5'd6, 1'b1, "l6_e1");
        irq_en_i[6] = 1'b0;
        cyc(1'b0, 5'd0, 1'b0, "l6_withdraw");
        chk_pend(32'h0000_0040, 32'h0000_0040, "l6_pend");
        cyc(1'b0, 5'd0, 1'b0, "l6_masked");
        irq_en_i[6] = 1'b1;
        cyc(1'b1, 5'd6, 1'b1, "l6_repres");
        irq_en_i[6] = 1'b0;
        irq_ack_i   = 1'b1;
        cyc(1'b0, 5'd0, 1'b0, "l6_ack_wd");
        irq_en_i[6] = 1'b1;
        irq_ack_i   = 1'b0;
        cyc(1'b0, 5'd0, 1'b0, "l6_waitclr");
        cyc(1'b1, 5'd6, 1'b1, "l6_again");
        irq_src_i[6] = 1'b0;
        irq_ack_i    = 1'b1;
        cyc(1'b0, 5'd0, 1'b0, "l6_ack");
        irq_ack_i = 1'b0;
        cyc(1'b0, 5'd0, 1'b0, "l6_idle0");
        cyc(1'b0, 5'd0, 1'b0, "l6_idle1");

        // Edges 1 and 9 latched while masked; ack in IDLE is ignored
        irq_en_i[1] = 1'b0;
        irq_en_i[9] = 1'b0;
        irq_src_i[1] = 1'b1;
        irq_src_i[9] = 1'b1;
        cyc(1'b0, 5'd0, 1'b0, "e19_set");
        irq_src_i[1] = 1'b0;
        irq_src_i[9] = 1'b0;
        irq_ack_i    = 1'b1;
        cyc(1'b0, 5'd0, 1'b0, "e19_idle_ack");
        irq_ack_i = 1'b0;
        chk_pend(32'hFFFF_FFFF, 32'h0000_0202, "e19_pend");
        irq_en_i = '1;
        cyc(1'b1, 5'd1, 1'b1, "e19_id1");

        // Reset mid-PRESENT; source 5 held high across release acts as edge
        rst          = 1'b1;
        irq_src_i[5] = 1'b1;
        cyc(1'b0, 5'd0, 1'b1, "rst_mid");
        chk_pend(32'hFFFF_FFFF, 32'h0, "rst_pend");
        rst = 1'b0;
        cyc(1'b0, 5'd0, 1'b1, "rel_e0");
        chk_pend(32'hFFFF_FFFF, 32'h0000_0020, "rel_pend");
        cyc(1'b1, 5'd5, 1'b1, "rel_id5");
        irq_ack_i = 1'b1;
        cyc(1'b0, 5'd0, 1'b0, "rel_ack");
        irq_ack_i = 1'b0;
        cyc(1'b0, 5'd0, 1'b0, "rel_wait");
        cyc(1'b0, 5'd0, 1'b0, "rel_idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
